// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, data (LSB first), optional parity and stop
// fields. Define UART_TX_BACK2BACK_EN to accept a new payload in the STOP cycle (no IDLE gap).
module uart_tx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  localparam logic [1:0] MuxStart  = 2'b00;
  localparam logic [1:0] MuxStop   = 2'b01;
  localparam logic [1:0] MuxData   = 2'b10;
  localparam logic [1:0] MuxParity = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [CntW-1:0]       next_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  accept;

`ifdef UART_TX_BACK2BACK_EN
  assign accept = DATA_VALID && ((state_q == StIdle) || (state_q == StStop));
`else
  assign accept = DATA_VALID && (state_q == StIdle);
`endif

  assign next_idx = bit_cnt_q + CntW'(1);

  // State and all outputs live in one register block so outputs come straight from flops.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit   <= 1'b0;
      ser_data  <= 1'b0;
      busy      <= 1'b0;
      mux_sel   <= MuxStop;
    end else begin
      if (accept) begin
        data_q   <= P_DATA;
        par_en_q <= PAR_EN;
        par_bit  <= (^P_DATA) ^ PAR_TYP;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StStart;
            mux_sel <= MuxStart;
            busy    <= 1'b1;
          end
        end

        StStart: begin
          state_q  <= StData;
          mux_sel  <= MuxData;
          ser_data <= data_q[0];
        end

        StData: begin
          if (bit_cnt_q == LastIdx) begin
            bit_cnt_q <= '0;
            ser_data  <= 1'b0;
            if (par_en_q) begin
              state_q <= StParity;
              mux_sel <= MuxParity;
            end else begin
              state_q <= StStop;
              mux_sel <= MuxStop;
            end
          end else begin
            bit_cnt_q <= next_idx;
            ser_data  <= data_q[next_idx];
          end
        end

        StParity: begin
          state_q <= StStop;
          mux_sel <= MuxStop;
        end

        StStop: begin
          // accept can only be true here in the back-to-back build.
          if (accept) begin
            state_q <= StStart;
            mux_sel <= MuxStart;
            busy    <= 1'b1;
          end else begin
            state_q <= StIdle;
            mux_sel <= MuxStop;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q   <= StIdle;
          bit_cnt_q <= '0;
          mux_sel   <= MuxStop;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of payload bits per frame; legal range 5..9.
REQ-002 CLK  input  1  bit-rate clock; one CLK period equals one UART bit time.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance.
REQ-005 DATA_VALID  input  1  payload request; accepted per REQ-010.
REQ-006 PAR_EN  input  1  1 = parity bit inserted; sampled on acceptance.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on acceptance.
REQ-008 mux_sel  output  2  frame-field select: 00 start, 01 stop/idle, 10 serial data, 11 parity.
REQ-009 ser_data, par_bit, busy  output  1 each  current payload bit; computed parity bit; frame in progress.

Function
REQ-010 Acceptance SHALL occur on a rising CLK edge where state is IDLE and DATA_VALID=1; the edge latches P_DATA, PAR_EN and PAR_TYP into internal registers.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, held in one state register updated on the rising CLK edge.
REQ-012 Transitions SHALL be: IDLE->START on acceptance; START->DATA after 1 cycle; DATA->PARITY (latched PAR_EN=1) or DATA->STOP (latched PAR_EN=0) after DATA_WIDTH cycles; PARITY->STOP after 1 cycle; STOP->IDLE after 1 cycle.
REQ-013 A bit counter SHALL count DATA cycles from 0 to DATA_WIDTH-1, SHALL clear on leaving DATA, and SHALL never wrap inside one frame.
REQ-014 ser_data SHALL present latched payload bit[k] during the k-th DATA cycle, LSB first; outside DATA its value is don't-care but it SHALL be glitch-free from registers.
REQ-015 par_bit SHALL equal the XOR of all latched payload bits when latched PAR_TYP=0; it SHALL equal the inverse of that XOR when latched PAR_TYP=1. It SHALL be computed at acceptance and held stable until the next acceptance.
REQ-016 mux_sel SHALL decode the current state: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-017 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-018 Frame length SHALL be DATA_WIDTH+2+PAR_EN cycles, measured from the first START cycle through the last STOP cycle.
REQ-019 DATA_VALID while busy=1 SHALL be ignored; P_DATA, PAR_EN and PAR_TYP changes while busy=1 SHALL NOT affect the frame in flight (configuration exception in REQ-023).
REQ-020 DATA_VALID held high continuously SHALL produce one frame per IDLE visit, with exactly one IDLE cycle between frames.

Reset
REQ-021 RST=0 sampled on a rising CLK edge SHALL force: state IDLE, bit counter 0, latched data 0, par_bit 0, ser_data 0, busy 0 and mux_sel 01. This SHALL hold in any state.
REQ-022 Reset mid-frame SHALL abandon the frame with no stop-bit completion; with RST=1 and DATA_VALID=1, the first acceptance SHALL occur on the first rising edge after release.

Configuration
REQ-023 With macro UART_TX_BACK2BACK_EN defined, acceptance SHALL also occur in the STOP cycle: STOP->START directly, inserting no IDLE cycle, and busy remains 1. Without the macro, acceptance SHALL occur only in IDLE, per REQ-010 and REQ-020.

Verification
REQ-024 DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> mux_sel 00, then 10 x8, then 11, then 01; ser_data 1,0,1,0,0,1,0,1; par_bit=0; busy high for 11 cycles.
REQ-025 P_DATA=0x01, PAR_EN=1: PAR_TYP=0 -> par_bit=1; PAR_TYP=1 -> par_bit=0.
REQ-026 P_DATA=0xFF, PAR_EN=0 -> no mux_sel 11 cycle; busy high for exactly 10 cycles; then mux_sel 01 with busy 0.
REQ-027 While busy, pulse DATA_VALID with P_DATA=0x3C and toggle PAR_TYP -> in-flight frame bits and par_bit unchanged; no second frame.
REQ-028 Reset asserted in 4th DATA cycle -> next edge: mux_sel 01, busy 0; DATA_VALID after release -> clean START with new payload.
REQ-029 DATA_VALID held high: without the macro -> one IDLE cycle (mux_sel 01, busy 0) between frames; with UART_TX_BACK2BACK_EN -> START follows STOP directly, busy continuously 1.
